pmod_jstk_spi_responder: RTL and testbench
==========================================

Name: pmod_jstk_spi_responder

Overview:
SPI mode-0 responder that emulates the PmodJSTK joystick module, i.e. the peripheral end of the joystick link our SPI master polls.
- Serves a 5-byte frame built from snapshot X/Y/button inputs.
- Captures the master's command byte to drive the two emulated joystick LEDs.
- Used as a bench/loopback stand-in for the physical joystick, and on a second board to forward a local stick to the game board.

Parameters:
SYNC_STAGES, 2, synchronizer depth (>=2) for sclk/ss/mosi into clk domain
FRAME_BYTES, 5, bytes per frame; fixed protocol value, not to be overridden

Ports:
clk       input   1   system clock; must be >= 8x sclk frequency
rst       input   1   asynchronous, active-low reset
sclk      input   1   SPI clock from master, CPOL=0 CPHA=0
ss        input   1   slave select from master, active low
mosi      input   1   master-out data, MSB first
miso      output  1   slave-out data, MSB first
miso_oe   output  1   1 while ss asserted (synchronized); 0 otherwise
x_pos     input   10  X position to report
y_pos     input   10  Y position to report
buttons   input   3   {btn2, btn1, trigger} to report
led_ctl   output  2   LED state commanded by the master
cmd_byte  output  8   last complete first-byte received
frame_ok  output  1   one-cycle pulse when a full 40-bit frame completes
frame_err output  1   one-cycle pulse when ss deasserts mid-frame

Behaviour:
- Reset (rst=0, async) values: miso=0, miso_oe=0, led_ctl=0, cmd_byte=0, frame_ok=0, frame_err=0, bit counter=0, state=IDLE.
- Synchronization: sclk/ss/mosi each pass through SYNC_STAGES flops. Edges are detected on synchronized values (prev vs current).
- States:
  - IDLE: wait for ss falling edge. On it:
    - snapshot tx frame = {x_pos[7:0], 6'b0,x_pos[9:8], y_pos[7:0], 6'b0,y_pos[9:8], 5'b0,buttons} (byte0 first).
    - load tx shifter, miso = frame bit 39 (MSB of byte0) on the same cycle; bit_cnt=0; go SHIFT.
  - SHIFT:
    - sclk rising edge: shift synchronized mosi into rx shifter; bit_cnt++.
    - When bit_cnt reaches 8, copy rx shifter to cmd_byte (first byte only).
    - sclk falling edge: present next tx bit on miso. After bit 40, miso=0.
    - ss rising edge:
      - bit_cnt>=40: frame_ok pulse; if cmd_byte[7]==1 then led_ctl=cmd_byte[1:0], else led_ctl unchanged. Go IDLE.
      - bit_cnt<40: frame_err pulse, led_ctl unchanged, go IDLE. cmd_byte keeps any value already captured at bit 8.
- Extra clocks past 40 bits: ignored (bit_cnt saturates at 40), miso=0, still frame_ok at ss rise.
- Inputs x_pos/y_pos/buttons changing mid-frame: no effect on the frame in flight.
- Simultaneous sclk edge and ss rise in the same cycle: the ss rise wins; that sclk edge is discarded.
- ss low at reset release: remain IDLE until a fresh ss falling edge; no response to that frame.
- miso_oe = synchronized ss inverted; miso forced 0 when miso_oe=0.
- Latency: miso updates SYNC_STAGES+1 clk cycles after a physical sclk falling edge. Master samples on the rising edge, so a half sclk period must exceed (SYNC_STAGES+2) clk periods.

Optional Feature:
JSTK_RESP_STATS_EN
- Defined: adds outputs ok_count[15:0] and err_count[15:0]. These increment on frame_ok and frame_err respectively, wrap at 0xFFFF->0, and reset to 0.
- Undefined: neither port nor counters exist; all other behaviour is identical.

Test Plan:
- x_pos=10'h2A5, y_pos=10'h13C, buttons=3'b101; master sends 40 bits with mosi bytes 0x83,0,0,0,0 -> miso bytes A5,02,3C,01,05; frame_ok pulses once; led_ctl=2'b11; cmd_byte=0x83.
- First byte 0x02 (bit7=0), full frame -> frame_ok; led_ctl holds previous 2'b11.
- ss deasserted after 20 bits, first byte 0x81 -> frame_err pulse, no frame_ok, led_ctl unchanged, cmd_byte=0x81.
- x_pos changed from 10'h000 to 10'h3FF after bit 4 of a frame -> frame still returns 00,00 for X; next frame returns FF,03.
- 48 sclk cycles in one frame -> bytes 6 onward read 0x00; single frame_ok.
- rst pulsed low mid-frame -> all outputs return to reset values immediately; next complete frame is served correctly. With JSTK_RESP_STATS_EN defined, counters read 0 after reset and 1 after that frame.

Source files
------------

// File: rtl/pmod_jstk_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : pmod_jstk_spi_responder
// Purpose  : SPI mode-0 peripheral that emulates a PmodJSTK joystick. Serves
//            a 5-byte X/Y/button frame on miso and captures the master's first
//            (command) byte to drive two emulated LEDs.
// Options  : define JSTK_RESP_STATS_EN to add ok_count/err_count frame counters
// Revision : 1.0 - initial release
// ============================================================================
module pmod_jstk_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BYTES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        ss,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    input  logic [2:0]  buttons,
    output logic [1:0]  led_ctl,
    output logic [7:0]  cmd_byte,
    output logic        frame_ok,
`ifdef JSTK_RESP_STATS_EN
    output logic [15:0] ok_count,
    output logic [15:0] err_count,
`endif
    output logic        frame_err
);

    localparam int                c_FRAME_BITS = FRAME_BYTES * 8;
    localparam int                c_CNT_W      = $clog2(c_FRAME_BITS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL  = c_CNT_W'(c_FRAME_BITS);
    localparam logic [c_CNT_W-1:0] c_CNT_BYTE  = c_CNT_W'(7);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                    r_state;
    logic [SYNC_STAGES-1:0]    r_sclk_sync;
    logic [SYNC_STAGES-1:0]    r_ss_sync;
    logic [SYNC_STAGES-1:0]    r_mosi_sync;
    logic                      r_sclk_prev;
    logic                      r_ss_prev;
    logic [c_CNT_W-1:0]        r_bit_cnt;
    logic [c_FRAME_BITS-2:0]   r_tx;
    logic [6:0]                r_rx;

    logic                      w_sclk;
    logic                      w_ss;
    logic                      w_mosi;
    logic                      w_sclk_rise;
    logic                      w_sclk_fall;
    logic                      w_ss_rise;
    logic                      w_ss_fall;
    logic [c_FRAME_BITS-1:0]   w_frame;

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss        = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise =  w_sclk & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk &  r_sclk_prev;
    assign w_ss_rise   =  w_ss   & ~r_ss_prev;
    assign w_ss_fall   = ~w_ss   &  r_ss_prev;

    // Byte 0 is sent first, MSB first; high X/Y bits and buttons are right-aligned
    assign w_frame = {x_pos[7:0], 6'b0, x_pos[9:8],
                      y_pos[7:0], 6'b0, y_pos[9:8],
                      5'b0, buttons};

    // Bring the SPI pins into the clk domain and keep a one-cycle history.
    // The ss chain resets low so a select already held low at reset release
    // never looks like a fresh falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_ss_prev   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0],   ss};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_prev <= w_sclk;
            r_ss_prev   <= w_ss;
        end
    end

    // Frame FSM: snapshot on select, shift on sclk edges, report on deselect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            led_ctl   <= 2'b00;
            cmd_byte  <= 8'h00;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            miso_oe   <= ~w_ss;
            case (r_state)
                S_IDLE: begin
                    miso <= 1'b0;
                    if (w_ss_fall) begin
                        r_tx      <= w_frame[c_FRAME_BITS-2:0];
                        miso      <= w_frame[c_FRAME_BITS-1];
                        r_bit_cnt <= '0;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Deselect takes priority over any sclk edge in the same cycle
                    if (w_ss_rise) begin
                        miso    <= 1'b0;
                        r_state <= S_IDLE;
                        if (r_bit_cnt >= c_CNT_FULL) begin
                            frame_ok <= 1'b1;
                            if (cmd_byte[7]) begin
                                led_ctl <= cmd_byte[1:0];
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        // Counter saturates at a full frame; extra clocks are ignored
                        if (w_sclk_rise && (r_bit_cnt != c_CNT_FULL)) begin
                            r_rx      <= {r_rx[5:0], w_mosi};
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == c_CNT_BYTE) begin
                                cmd_byte <= {r_rx, w_mosi};
                            end
                        end
                        // Zeros shift in behind the frame, so miso idles low past the end
                        if (w_sclk_fall) begin
                            miso <= r_tx[c_FRAME_BITS-2];
                            r_tx <= {r_tx[c_FRAME_BITS-3:0], 1'b0};
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef JSTK_RESP_STATS_EN
    // Free-running wrap-around counts of completed and aborted frames
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ok_count  <= 16'h0000;
            err_count <= 16'h0000;
        end else begin
            if (frame_ok) begin
                ok_count <= ok_count + 16'h0001;
            end
            if (frame_err) begin
                err_count <= err_count + 16'h0001;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration
`endif

endmodule
`default_nettype wire

// File: tb/tb_pmod_jstk_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmod_jstk_spi_responder
// Purpose  : Self-checking bench for pmod_jstk_spi_responder. A bit-banged SPI
//            master drives directed frames; a frame-level model predicts miso
//            bytes, command/LED state and frame pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmod_jstk_spi_responder;

    localparam int HALF = 8;   // sclk half period in clk cycles

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        ss = 1'b1;
    logic        mosi = 1'b0;
    logic [9:0]  x_pos = '0;
    logic [9:0]  y_pos = '0;
    logic [2:0]  buttons = '0;
    logic        miso;
    logic        miso_oe;
    logic [1:0]  led_ctl;
    logic [7:0]  cmd_byte;
    logic        frame_ok;
    logic        frame_err;
`ifdef JSTK_RESP_STATS_EN
    logic [15:0] ok_count;
    logic [15:0] err_count;
`endif

    pmod_jstk_spi_responder #(.SYNC_STAGES(2), .FRAME_BYTES(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .ss        (ss),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .buttons   (buttons),
        .led_ctl   (led_ctl),
        .cmd_byte  (cmd_byte),
        .frame_ok  (frame_ok),
`ifdef JSTK_RESP_STATS_EN
        .ok_count  (ok_count),
        .err_count (err_count),
`endif
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state (frame level)
    logic [1:0] m_led = 2'b00;
    logic [7:0] m_cmd = 8'h00;
    int         m_ok  = 0;
    int         m_err = 0;
    bit         m_valid = 1'b0;
    int         ok_seen = 0;
    int         err_seen = 0;
    logic [7:0] last_rx [0:5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            tick(HALF); sclk = 1'b1;
            tick(HALF); sclk = 1'b0;
        end
    endtask

    // One master transaction of nbits; optionally changes x_pos after bit chg_bit
    task automatic spi_frame(input logic [7:0] b0, input int nbits,
                             input int chg_bit, input logic [9:0] chg_x);
        logic [7:0]  mb  [0:5];
        logic [7:0]  exp [0:5];
        logic [47:0] rxv;
        int          ok0;
        int          err0;
        mb = '{b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp[0] = x_pos[7:0];
        exp[1] = {6'b0, x_pos[9:8]};
        exp[2] = y_pos[7:0];
        exp[3] = {6'b0, y_pos[9:8]};
        exp[4] = {5'b0, buttons};
        exp[5] = 8'h00;
        rxv  = '0;
        ok0  = ok_seen;
        err0 = err_seen;
        m_valid = 1'b0;
        ss = 1'b0;
        tick(HALF);
        for (int i = 0; i < nbits; i++) begin
            mosi = mb[i/8][7-(i%8)];
            tick(HALF);
            rxv[47-i] = miso;
            sclk = 1'b1;
            if (i == chg_bit) x_pos = chg_x;
            tick(HALF);
            sclk = 1'b0;
        end
        tick(HALF);
        ss   = 1'b1;
        mosi = 1'b0;
        tick(12);
        for (int k = 0; k < 6; k++) begin
            last_rx[k] = rxv[47-8*k -: 8];
            if (k < nbits/8) check("miso_byte", last_rx[k], exp[k]);
        end
        check("frame_ok_pulses",  ok_seen - ok0,   (nbits >= 40) ? 1 : 0);
        check("frame_err_pulses", err_seen - err0, (nbits <  40) ? 1 : 0);
        if (nbits >= 8) m_cmd = b0;
        if (nbits >= 40) begin
            m_ok++;
            if (m_cmd[7]) m_led = m_cmd[1:0];
        end else begin
            m_err++;
        end
        m_valid = 1'b1;
    endtask

    // Count single-cycle frame pulses
    always @(negedge clk) begin
        if (frame_ok)  ok_seen++;
        if (frame_err) err_seen++;
    end

    // Cycle compare against the model whenever the link is idle and settled
    always @(negedge clk) begin
        if (m_valid && rst) begin
            check("idle_led_ctl",  led_ctl,  m_led);
            check("idle_cmd_byte", cmd_byte, m_cmd);
            check("idle_miso_oe",  miso_oe,  1'b0);
            check("idle_miso",     miso,     1'b0);
`ifdef JSTK_RESP_STATS_EN
            check("ok_count",  ok_count,  m_ok[15:0]);
            check("err_count", err_count, m_err[15:0]);
`endif
        end
    end

    initial begin
        #2 rst = 1'b0;
        tick(5);
        check("rst_miso",      miso,      1'b0);
        check("rst_miso_oe",   miso_oe,   1'b0);
        check("rst_led_ctl",   led_ctl,   2'b00);
        check("rst_cmd_byte",  cmd_byte,  8'h00);
        check("rst_frame_ok",  frame_ok,  1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        rst = 1'b1;
        tick(10);
        m_valid = 1'b1;

        // Basic frame with LED command
        x_pos = 10'h2A5; y_pos = 10'h13C; buttons = 3'b101;
        spi_frame(8'h83, 40, -1, 10'h0);
        check("t1_byte0", last_rx[0], 8'hA5);
        check("t1_byte1", last_rx[1], 8'h02);
        check("t1_byte2", last_rx[2], 8'h3C);
        check("t1_byte3", last_rx[3], 8'h01);
        check("t1_byte4", last_rx[4], 8'h05);
        check("t1_led",   led_ctl,    2'b11);
        check("t1_cmd",   cmd_byte,   8'h83);

        // Command without bit 7 leaves LEDs alone
        spi_frame(8'h02, 40, -1, 10'h0);
        check("t2_led", led_ctl,  2'b11);
        check("t2_cmd", cmd_byte, 8'h02);

        // Aborted frame after 20 bits
        spi_frame(8'h81, 20, -1, 10'h0);
        check("t3_led", led_ctl,  2'b11);
        check("t3_cmd", cmd_byte, 8'h81);

        // Input change mid-frame affects only the next frame
        x_pos = 10'h000;
        spi_frame(8'h00, 40, 4, 10'h3FF);
        check("t4_x_lo", last_rx[0], 8'h00);
        check("t4_x_hi", last_rx[1], 8'h00);
        spi_frame(8'h00, 40, -1, 10'h0);
        check("t4_next_x_lo", last_rx[0], 8'hFF);
        check("t4_next_x_hi", last_rx[1], 8'h03);

        // Over-long frame: sixth byte reads zero
        spi_frame(8'h00, 48, -1, 10'h0);
        check("t5_byte5", last_rx[5], 8'h00);

        // Reset mid-frame after a command byte has been captured
        m_valid = 1'b0;
        ss = 1'b0;
        mosi = 1'b1;
        tick(HALF);
        pulses(10);
        rst = 1'b0;
        #1;
        check("t6_miso",      miso,      1'b0);
        check("t6_miso_oe",   miso_oe,   1'b0);
        check("t6_led",       led_ctl,   2'b00);
        check("t6_cmd",       cmd_byte,  8'h00);
        check("t6_frame_ok",  frame_ok,  1'b0);
        check("t6_frame_err", frame_err, 1'b0);
`ifdef JSTK_RESP_STATS_EN
        check("t6_ok_count",  ok_count,  16'h0000);
        check("t6_err_count", err_count, 16'h0000);
`endif
        ss = 1'b1; mosi = 1'b0; sclk = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(10);
        m_led = 2'b00; m_cmd = 8'h00; m_ok = 0; m_err = 0;
        m_valid = 1'b1;
        spi_frame(8'h81, 40, -1, 10'h0);
        check("t6_led_after", led_ctl,  2'b01);
        check("t6_cmd_after", cmd_byte, 8'h81);
`ifdef JSTK_RESP_STATS_EN
        check("t6_ok_after",  ok_count, 16'h0001);
`endif

        // Select held low across reset release: frame must be ignored
        begin
            int ok0;
            int err0;
            m_valid = 1'b0;
            ok0  = ok_seen;
            err0 = err_seen;
            rst = 1'b0;
            ss  = 1'b0;
            mosi = 1'b1;
            tick(3);
            rst = 1'b1;
            tick(6);
            pulses(40);
            tick(HALF);
            ss = 1'b1; mosi = 1'b0;
            tick(12);
            check("t7_no_ok",  ok_seen - ok0,   0);
            check("t7_no_err", err_seen - err0, 0);
            check("t7_cmd",    cmd_byte,        8'h00);
            m_led = 2'b00; m_cmd = 8'h00; m_ok = 0; m_err = 0;
            m_valid = 1'b1;
            tick(5);
        end

        m_valid = 1'b0;
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
